// File: rtl/adder_share_sched_if.sv
// Request/response bundle between the arithmetic clients and the shared adder scheduler.
interface adder_share_sched_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int WORDS      = 2
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int OPW  = WORDS * DATA_WIDTH;

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*OPW-1:0] req_a;
    logic [NUM_REQ*OPW-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [OPW-1:0]         rsp_sum;
    logic                   rsp_co;
    logic [ID_W-1:0]        rsp_id;

    // Client side: raises requests and consumes responses.
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_co, rsp_id
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_co, rsp_id
    );
endinterface

// File: rtl/adder_share_sched.sv
// Round-robin scheduler sharing one DATA_WIDTH-bit adder slice between NUM_REQ
// requesters; each multi-word addition runs serially, least significant word first.
module adder_share_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int WORDS      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_share_sched_if.slave   bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int OPW  = WORDS * DATA_WIDTH;
    localparam int KW   = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

    state_t              state, next_state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     winner;
    logic                grant_found;
    logic [ID_W:0]       cand;
    logic [OPW-1:0]      op_a, op_b, sum_reg;
    logic                carry_reg;
    logic                co_reg;
    logic [ID_W-1:0]     id_reg;
    logic [KW-1:0]       k;
    logic [DATA_WIDTH:0] add_res;
    logic                accept, rsp_fire, last_word;

    assign accept    = (state == IDLE) && grant_found;
    assign rsp_fire  = (state == RESP) && bus.rsp_ready;
    assign last_word = (k == KW'(WORDS - 1));

    // Pick the first valid requester at or after ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        winner      = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ))
                cand = cand - (ID_W+1)'(NUM_REQ);
            if (!grant_found && bus.req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                winner      = cand[ID_W-1:0];
            end
        end
    end

    // Grant is only offered while idle, to the single arbitration winner.
    always_comb begin
        bus.req_ready = '0;
        if (accept)
            bus.req_ready[winner] = 1'b1;
    end

    // One word of the shared adder slice, chained through carry_reg.
    always_comb begin
        add_res = {1'b0, op_a[k*DATA_WIDTH +: DATA_WIDTH]}
                + {1'b0, op_b[k*DATA_WIDTH +: DATA_WIDTH]}
                + {{DATA_WIDTH{1'b0}}, carry_reg};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic: accept, walk WORDS slices, then hold until the response is taken.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_found) next_state = ADD;
            ADD:     if (last_word) next_state = RESP;
            RESP:    if (bus.rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, accumulate one word per ADD cycle,
    // and advance the round-robin pointer past the requester just answered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            co_reg    <= 1'b0;
            id_reg    <= '0;
            k         <= '0;
        end else begin
            if (accept) begin
                op_a      <= bus.req_a[winner*OPW +: OPW];
                op_b      <= bus.req_b[winner*OPW +: OPW];
                id_reg    <= winner;
                carry_reg <= 1'b0;
                k         <= '0;
            end
            if (state == ADD) begin
                sum_reg[k*DATA_WIDTH +: DATA_WIDTH] <= add_res[DATA_WIDTH-1:0];
                carry_reg <= add_res[DATA_WIDTH];
                k         <= k + KW'(1);
                if (last_word)
                    co_reg <= add_res[DATA_WIDTH];
            end
            if (rsp_fire) begin
                if (id_reg == ID_W'(NUM_REQ - 1))
                    ptr <= '0;
                else
                    ptr <= id_reg + ID_W'(1);
            end
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_sum   = sum_reg;
    assign bus.rsp_co    = co_reg;
    assign bus.rsp_id    = id_reg;

endmodule

// File: tb/tb_adder_share_sched.sv
// Directed bench for adder_share_sched with the default 32-bit x 2-word, 4-requester setup.
module tb_adder_share_sched;
    localparam int DW  = 32;
    localparam int NR  = 4;
    localparam int WD  = 2;
    localparam int OPW = DW * WD;

    logic clk;
    logic rst_n;
    int   assertions = 0;
    int   failures   = 0;

    adder_share_sched_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .WORDS(WD)) bus ();

    adder_share_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .WORDS(WD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [OPW-1:0] op_a [NR];
    logic [OPW-1:0] op_b [NR];
    logic [OPW-1:0] exp_sum [NR];
    logic           exp_co [NR];

    task automatic check_output(input string tag, input logic [OPW-1:0] obs, input logic [OPW-1:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, " rsp_valid"}, OPW'(bus.rsp_valid), '0);
        check_output({tag, " req_ready"}, OPW'(bus.req_ready), '0);
        check_output({tag, " rsp_sum"},   bus.rsp_sum, '0);
        check_output({tag, " rsp_co"},    OPW'(bus.rsp_co), '0);
        check_output({tag, " rsp_id"},    OPW'(bus.rsp_id), '0);
    endtask

    // One complete transaction; operands are scrambled right after the accept edge.
    task automatic apply_stimulus(input string tag, input logic [NR-1:0] mask, input int id,
                                  input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                  input logic [OPW-1:0] sum, input logic co);
        logic [NR-1:0] exp_rdy;
        exp_rdy = 4'b0001 << id;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_a[id*OPW +: OPW] = a;
        bus.req_b[id*OPW +: OPW] = b;
        bus.req_valid = mask;
        bus.rsp_ready = 1'b0;
        #1;
        check_output({tag, " grant"}, OPW'(bus.req_ready), OPW'(exp_rdy));
        tick();
        bus.req_valid = '0;
        for (int w = 0; w < NR*OPW/32; w++) begin
            bus.req_a[w*32 +: 32] = $urandom;
            bus.req_b[w*32 +: 32] = $urandom;
        end
        #1;
        check_output({tag, " ready after accept"}, OPW'(bus.req_ready), '0);
        check_output({tag, " valid T+0"}, OPW'(bus.rsp_valid), '0);
        tick();
        check_output({tag, " valid T+1"}, OPW'(bus.rsp_valid), '0);
        tick();
        check_output({tag, " valid T+2"}, OPW'(bus.rsp_valid), 1);
        check_output({tag, " sum"}, bus.rsp_sum, sum);
        check_output({tag, " co"},  OPW'(bus.rsp_co), OPW'(co));
        check_output({tag, " id"},  OPW'(bus.rsp_id), OPW'(id));
        bus.rsp_ready = 1'b1;
        tick();
        check_output({tag, " valid after rsp"}, OPW'(bus.rsp_valid), '0);
        bus.rsp_ready = 1'b0;
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};
    int n_grant, n_rsp, last_cyc, gid, rid;

    // Directed sequence covering all six scenarios in order.
    initial begin
        op_a[0] = 64'h00000001_80000000; op_b[0] = 64'h00000002_80000000;
        exp_sum[0] = 64'h00000004_00000000; exp_co[0] = 1'b0;
        op_a[1] = 64'h12345678_9ABCDEF0; op_b[1] = 64'h11111111_11111111;
        exp_sum[1] = 64'h23456789_ABCDF001; exp_co[1] = 1'b0;
        op_a[2] = 64'h80000000_00000000; op_b[2] = 64'h80000000_00000005;
        exp_sum[2] = 64'h00000000_00000005; exp_co[2] = 1'b1;
        op_a[3] = 64'h0000FFFF_FFFF0000; op_b[3] = 64'h00000001_00010000;
        exp_sum[3] = 64'h00010001_00000000; exp_co[3] = 1'b0;

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;

        $display("[TB] step 1: carry across words");
        apply_stimulus("t1", 4'b0100, 2, 64'h00000000_FFFFFFFF, 64'h00000000_00000001,
                       64'h00000001_00000000, 1'b0);

        $display("[TB] step 2: full overflow");
        apply_stimulus("t2", 4'b0001, 0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF,
                       64'hFFFFFFFF_FFFFFFFE, 1'b1);

        $display("[TB] step 3: all requesters contending");
        rst_n = 1'b0;
        #1;
        check_output("t3 reset valid", OPW'(bus.rsp_valid), '0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i*OPW +: OPW] = op_a[i];
            bus.req_b[i*OPW +: OPW] = op_b[i];
        end
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        n_grant = 0; n_rsp = 0; last_cyc = 0;
        for (int cyc = 0; cyc < 40 && (n_grant < 5 || n_rsp < 5); cyc++) begin
            #1;
            if (bus.req_ready != '0) begin
                gid = 0;
                for (int j = 0; j < NR; j++) if (bus.req_ready[j]) gid = j;
                check_output("t3 grant onehot", OPW'($onehot(bus.req_ready)), 1);
                if (n_grant < 5) begin
                    check_output("t3 grant order", OPW'(gid), OPW'(exp_order[n_grant]));
                    if (n_grant > 0)
                        check_output("t3 grant spacing", OPW'(cyc - last_cyc), OPW'(WD + 2));
                end
                last_cyc = cyc;
                n_grant++;
            end
            if (bus.rsp_valid && bus.rsp_ready && n_rsp < 5) begin
                rid = exp_order[n_rsp];
                check_output("t3 rsp id",  OPW'(bus.rsp_id), OPW'(rid));
                check_output("t3 rsp sum", bus.rsp_sum, exp_sum[rid]);
                check_output("t3 rsp co",  OPW'(bus.rsp_co), OPW'(exp_co[rid]));
                n_rsp++;
            end
            tick();
            if (n_grant >= 5) bus.req_valid = '0;
        end
        check_output("t3 grant count", OPW'(n_grant), 5);
        check_output("t3 rsp count", OPW'(n_rsp), 5);
        bus.rsp_ready = 1'b0;

        $display("[TB] step 4: response back-pressure");
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_a[1*OPW +: OPW] = op_a[1];
        bus.req_b[1*OPW +: OPW] = op_b[1];
        bus.req_valid = 4'b1111;
        #1;
        check_output("t4 grant", OPW'(bus.req_ready), OPW'(4'b0010));
        tick();
        check_output("t4 ready in add", OPW'(bus.req_ready), '0);
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            check_output("t4 hold valid", OPW'(bus.rsp_valid), 1);
            check_output("t4 hold sum",   bus.rsp_sum, exp_sum[1]);
            check_output("t4 hold id",    OPW'(bus.rsp_id), 1);
            check_output("t4 hold ready", OPW'(bus.req_ready), '0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        check_output("t4 next grant", OPW'(bus.req_ready), OPW'(4'b0100));
        bus.req_valid = '0;
        tick();

        $display("[TB] step 5: operands change after accept");
        apply_stimulus("t5", 4'b1000, 3, op_a[3], op_b[3], exp_sum[3], exp_co[3]);

        $display("[TB] step 6: reset during ADD");
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_a[2*OPW +: OPW] = op_a[2];
        bus.req_b[2*OPW +: OPW] = op_b[2];
        bus.req_valid = 4'b0100;
        #1;
        check_output("t6 grant", OPW'(bus.req_ready), OPW'(4'b0100));
        tick();
        bus.req_valid = '0;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6 abort");
        tick();
        tick();
        check_output("t6 no rsp", OPW'(bus.rsp_valid), '0);
        rst_n = 1'b1;
        tick();
        check_output("t6 still no rsp", OPW'(bus.rsp_valid), '0);
        apply_stimulus("t6", 4'b1001, 0, op_a[0], op_b[0], exp_sum[0], exp_co[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
